// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, FSM state type and helpers for the fetch stage
//
// Purpose: definitions used by the fetch top, its FIFO and the bus interface.
// Ports:   none (package).

package fetch_pkg;

  localparam logic [4:0] OP_HALT     = 5'b00000;
  localparam int         FETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    SQUASH,
    HALTED
  } fetch_state_e;

  // A fetched word halts the stage when its major opcode field is OP_HALT.
  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - bus bundle between fetch, instruction memory, branch unit and decode
//
// Purpose: groups every fetch-stage signal except clk/rst.
// Ports (master = fetch side):
//   out: imem_req, imem_addr, inst_out, pc2_out, inst_valid, halted, err
//   in : imem_rdy, imem_data, redirect_en, redirect_pc, dec_ready

interface fetch_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic [15:0] inst_out;
  logic [15:0] pc2_out;
  logic        inst_valid;
  logic        dec_ready;
  logic        halted;
  logic        err;

  modport master (
    output imem_req, imem_addr, inst_out, pc2_out, inst_valid, halted, err,
    input  imem_rdy, imem_data, redirect_en, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_out, pc2_out, inst_valid, halted, err,
    output imem_rdy, imem_data, redirect_en, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry {inst, pc+2} buffer between fetch and decode
//
// Purpose: holds fetched words until decode takes them; the head is always
//          entry 0, so it comes straight from a register.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   flush         drop all entries (wins over push/pop)
//   push, din     write a 32-bit entry
//   pop           remove the head (ignored when empty)
//   count         number of valid entries (0..2)
//   head          entry 0 contents

module fetch_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [1:0]  count,
  output logic [31:0] head
);

  localparam logic [1:0] DEPTH = 2'(FETCH_DEPTH);

  logic [31:0] e0;
  logic [31:0] e1;
  logic [1:0]  cnt;
  logic        do_pop;
  logic        do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt < DEPTH) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      e0  <= 32'h0;
      e1  <= 32'h0;
      cnt <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (cnt == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt;
  assign head  = e0;

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction-fetch stage: PC, memory handshake, redirect/squash, HALT
//
// Purpose: fetches 16-bit words into a 2-entry FIFO feeding decode.
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   bus   fetch_if.master: imem_req/addr/rdy/data memory handshake,
//         redirect_en/pc, inst_out/pc2_out/inst_valid/dec_ready to decode,
//         halted, err status

module fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  fetch_state_e state, next_state;
  logic [15:0]  pc, pc_next;
  logic [15:0]  sq_addr, sq_next;
  logic         err_q, err_next;
  logic         live;
  logic         req;
  logic         accept;
  logic         pop_ok;
  logic         push;
  logic         flush;
  logic [1:0]   count;
  logic [31:0]  head;
  logic [2:0]   count_after;

  // live holds off the first request until the cycle after reset is released.
  assign req    = live && ((state == FETCH) || (state == SQUASH));
  assign accept = req && (state == FETCH) && bus.imem_rdy;
  assign pop_ok = bus.dec_ready && (count != 2'd0);

  // Occupancy after this edge's accept and pop; used for the room check.
  assign count_after = {1'b0, count} + 3'd1 - {2'b00, pop_ok};

  always_comb begin
    next_state = state;
    pc_next    = pc;
    sq_next    = sq_addr;
    err_next   = err_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (bus.redirect_en) begin
      flush = 1'b1;
      if (bus.redirect_pc[0]) begin
        err_next   = 1'b1;
        next_state = HALTED;
      end else begin
        pc_next = bus.redirect_pc;
        if (err_q) begin
          next_state = HALTED;
        end else if (req && !bus.imem_rdy) begin
          // The in-flight request must still complete at its old address.
          next_state = SQUASH;
          if (state == FETCH) sq_next = pc;
        end else begin
          next_state = FETCH;
        end
      end
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            push    = 1'b1;
            pc_next = pc + 16'd2;
            if (is_halt(bus.imem_data))  next_state = HALTED;
            else if (count_after >= 3'd2) next_state = WAIT;
          end
        end
        WAIT:    if (pop_ok) next_state = FETCH;
        SQUASH:  if (bus.imem_rdy) next_state = FETCH;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      sq_addr <= RESET_PC;
      err_q   <= 1'b0;
      live    <= 1'b0;
    end else begin
      state   <= next_state;
      pc      <= pc_next;
      sq_addr <= sq_next;
      err_q   <= err_next;
      live    <= 1'b1;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   ({bus.imem_data, pc + 16'd2}),
    .pop   (pop_ok),
    .count (count),
    .head  (head)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = (state == SQUASH) ? sq_addr : pc;
  assign bus.inst_out   = head[31:16];
  assign bus.pc2_out    = head[15:0];
  assign bus.inst_valid = (count != 2'd0);
  assign bus.halted     = (state == HALTED);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for the fetch stage

module tb_fetch;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic mem_auto;
  logic halt_on;
  logic [15:0] halt_addr;

  fetch_if bus();

  fetch #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dr;
    logic        re;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] inst;
    logic [15:0] pc2;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_on && a == halt_addr) return 16'h0000;
    return 16'h4000 | (a << 7);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present the memory response for the current request, then advance one edge.
  task automatic step();
    if (mem_auto) begin
      bus.imem_rdy  = bus.imem_req;
      bus.imem_data = mem_word(bus.imem_addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mem_auto  = 1'b1;
    halt_on   = 1'b0;
    halt_addr = 16'h0006;
    rst = 1'b0;
    bus.imem_rdy    = 1'b0;
    bus.imem_data   = 16'h0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 16'h0;
    bus.dec_ready   = 1'b1;

    //            dr    re    rpc       req   addr      vld   inst      pc2
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h4000, 16'h0002};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h4100, 16'h0004};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h4100, 16'h0004};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h4100, 16'h0004};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h4100, 16'h0004};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h4100, 16'h0004};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h4100, 16'h0004};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h4200, 16'h0006};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h4300, 16'h0008};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b1, 16'h4300, 16'h0008};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b1, 16'h4400, 16'h000A};
    tbl[12] = '{1'b1, 1'b1, 16'h0020, 1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0000};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0022, 1'b1, 16'h5000, 16'h0022};

    // Reset values
    repeat (3) step();
    chk("rst req",   16'(bus.imem_req), 16'h0);
    chk("rst addr",  bus.imem_addr, 16'h0000);
    chk("rst vld",   16'(bus.inst_valid), 16'h0);
    chk("rst inst",  bus.inst_out, 16'h0000);
    chk("rst pc2",   bus.pc2_out, 16'h0000);
    chk("rst halt",  16'(bus.halted), 16'h0);
    chk("rst err",   16'(bus.err), 16'h0);
    rst = 1'b1;

    // Streaming, backpressure and redirect-with-response vectors
    for (int i = 0; i < 14; i++) begin
      bus.dec_ready   = tbl[i].dr;
      bus.redirect_en = tbl[i].re;
      bus.redirect_pc = tbl[i].rpc;
      step();
      chk($sformatf("row%0d req", i),  16'(bus.imem_req), 16'(tbl[i].req));
      chk($sformatf("row%0d addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("row%0d vld", i),  16'(bus.inst_valid), 16'(tbl[i].vld));
      chk($sformatf("row%0d halt", i), 16'(bus.halted), 16'h0);
      if (tbl[i].vld) begin
        chk($sformatf("row%0d inst", i), bus.inst_out, tbl[i].inst);
        chk($sformatf("row%0d pc2", i),  bus.pc2_out, tbl[i].pc2);
      end
    end
    bus.redirect_en = 1'b0;

    // Mid-operation reset with a response on the same edge
    rst = 1'b0;
    step();
    chk("midrst req",  16'(bus.imem_req), 16'h0);
    chk("midrst vld",  16'(bus.inst_valid), 16'h0);
    chk("midrst addr", bus.imem_addr, 16'h0000);
    chk("midrst inst", bus.inst_out, 16'h0000);

    // Squash: redirect while request outstanding, memory late by 3 cycles
    mem_auto = 1'b0;
    bus.imem_rdy = 1'b0;
    rst = 1'b1;
    step();
    chk("sq start req", 16'(bus.imem_req), 16'h1);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 16'h0030;
    step();
    chk("sq1 req",  16'(bus.imem_req), 16'h1);
    chk("sq1 addr", bus.imem_addr, 16'h0000);
    chk("sq1 vld",  16'(bus.inst_valid), 16'h0);
    bus.redirect_pc = 16'h0040;
    step();
    chk("sq2 addr", bus.imem_addr, 16'h0000);
    bus.redirect_en = 1'b0;
    step();
    chk("sq3 req",  16'(bus.imem_req), 16'h1);
    chk("sq3 addr", bus.imem_addr, 16'h0000);
    bus.imem_rdy  = 1'b1;
    bus.imem_data = 16'h1234;
    step();
    chk("sq done addr", bus.imem_addr, 16'h0040);
    chk("sq done vld",  16'(bus.inst_valid), 16'h0);
    mem_auto = 1'b1;
    step();
    chk("sq fetch vld",  16'(bus.inst_valid), 16'h1);
    chk("sq fetch inst", bus.inst_out, 16'h6000);
    chk("sq fetch pc2",  bus.pc2_out, 16'h0042);

    // HALT word at 0006
    rst = 1'b0;
    step();
    rst = 1'b1;
    halt_on = 1'b1;
    repeat (4) step();
    chk("pre halt addr", bus.imem_addr, 16'h0006);
    step();
    chk("halt vld",  16'(bus.inst_valid), 16'h1);
    chk("halt inst", bus.inst_out, 16'h0000);
    chk("halt pc2",  bus.pc2_out, 16'h0008);
    chk("halt flag", 16'(bus.halted), 16'h1);
    chk("halt req",  16'(bus.imem_req), 16'h0);
    step();
    chk("halt2 vld", 16'(bus.inst_valid), 16'h0);
    chk("halt2 req", 16'(bus.imem_req), 16'h0);
    step();
    chk("halt3 req", 16'(bus.imem_req), 16'h0);
    chk("halt3 flag", 16'(bus.halted), 16'h1);
    halt_on = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 16'h0010;
    step();
    chk("resume halt", 16'(bus.halted), 16'h0);
    chk("resume req",  16'(bus.imem_req), 16'h1);
    chk("resume addr", bus.imem_addr, 16'h0010);
    bus.redirect_en = 1'b0;
    step();
    chk("resume inst", bus.inst_out, 16'h4800);
    chk("resume pc2",  bus.pc2_out, 16'h0012);

    // Misaligned redirect
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 16'h0011;
    step();
    chk("err flag", 16'(bus.err), 16'h1);
    chk("err halt", 16'(bus.halted), 16'h1);
    chk("err vld",  16'(bus.inst_valid), 16'h0);
    chk("err req",  16'(bus.imem_req), 16'h0);
    bus.redirect_pc = 16'h0020;
    step();
    chk("err redir halt", 16'(bus.halted), 16'h1);
    bus.redirect_en = 1'b0;
    step();
    chk("err sticky", 16'(bus.err), 16'h1);
    rst = 1'b0;
    step();
    chk("err clr", 16'(bus.err), 16'h0);
    chk("err clr halt", 16'(bus.halted), 16'h0);

    // PC wrap at FFFE
    rst = 1'b1;
    step();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    step();
    chk("wrap addr0", bus.imem_addr, 16'hFFFE);
    chk("wrap vld0",  16'(bus.inst_valid), 16'h0);
    bus.redirect_en = 1'b0;
    step();
    chk("wrap addr", bus.imem_addr, 16'h0000);
    chk("wrap inst", bus.inst_out, 16'hFF00);
    chk("wrap pc2",  bus.pc2_out, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the 16-bit pipeline, directly upstream of the decode stage. Holds the PC and runs a request/ready handshake with instruction memory. Buffers up to two fetched words in a small FIFO and presents them to decode with a valid/ready handshake. Supports branch/jump redirects with squash of in-flight fetches, and stops fetching after a HALT.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC loaded on reset

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset), sampled on rising clk
- imem_req  out  1  fetch request; held until accepted
- imem_addr  out  16  fetch address; stable while imem_req=1
- imem_rdy  in  1  memory response valid; completes the request on an edge where imem_req=1
- imem_data  in  16  instruction word; valid when imem_rdy=1
- redirect_en  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  16  redirect target
- inst_out  out  16  instruction at FIFO head, to decode
- pc2_out  out  16  address of inst_out + 2
- inst_valid  out  1  FIFO head valid
- dec_ready  in  1  decode accepts head this cycle
- halted  out  1  fetch stopped by HALT or error
- err  out  1  sticky misaligned-redirect error

## Operation
- FSM states:
  - FETCH: imem_req=1
  - WAIT: no request, FIFO lacks room
  - SQUASH: request outstanding whose response is discarded
  - HALTED
- Room rule: issue a request only if fifo_count + outstanding < 2.
  - FETCH→WAIT when an accept would leave no room.
  - WAIT→FETCH once a pop frees an entry.
- Accept (FETCH, imem_rdy=1, no redirect): push {imem_data, pc+2}; pc ← pc+2, mod 2^16 (16'hFFFE+2 = 16'h0000).
- HALT: an accepted word with imem_data[15:11] = 5'b00000 is pushed and delivered normally; the FSM then goes to HALTED and issues no further requests.
- Pop: on inst_valid & dec_ready; pop and push in the same cycle are allowed.
- Redirect, when redirect_en=1 on an edge:
  - FIFO is flushed and pc ← redirect_pc.
  - If a request is outstanding and imem_rdy=0, go to SQUASH.
  - If imem_rdy=1 on that same edge, the response is dropped and the FSM goes to FETCH.
  - Redirect has priority over accept, pop and HALT.
  - A redirect leaves HALTED unless err=1.
- SQUASH: imem_req stays 1 with imem_addr frozen at the old address until imem_rdy; the data is discarded. Next state is FETCH at the new pc.
  - A second redirect during SQUASH updates pc only.
- Error: redirect_en=1 with redirect_pc[0]=1 sets err (sticky until reset), flushes the FIFO and goes to HALTED.
- halted = (state==HALTED).

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - inst_valid=0, inst_out=16'h0000, pc2_out=16'h0000
  - halted=0, err=0
  - FIFO empty, state FETCH
- imem_req first asserts in the cycle after rst returns to 1.
- Reset asserted mid-operation overrides everything on that edge. Any memory response in that cycle is ignored.
- Minimum fetch latency: request and imem_rdy in the same cycle → inst_valid=1 in the next cycle.
- Throughput: 1 instruction/cycle with a zero-wait memory and dec_ready=1.
- inst_out and pc2_out come from registers. inst_valid changes only on a clock edge.
- Redirect: inst_valid=0 in the cycle after the redirect edge.
  - If nothing is outstanding, imem_addr=redirect_pc in that same cycle.

## Structure
- Shared package holds:
  - OP_HALT = 5'b00000
  - fetch FSM state typedef (FETCH, WAIT, SQUASH, HALTED)
  - FETCH_DEPTH = 2
- Sub-module fetch_fifo: 2-entry, 32-bit ({inst, pc+2}) FIFO with push, pop, synchronous flush, count and head outputs. Same synchronous active-low rst.
- Top level contains the PC register, FSM, outstanding flag and err flop.

## Test plan
- Reset release, zero-wait memory returning 16'h4000, 16'h4100, dec_ready=1:
  - imem_addr sequence 0000, 0002, 0004
  - inst_out 4000, 4100 on consecutive cycles
  - pc2_out 0002, 0004
- dec_ready=0 for 5 cycles:
  - exactly 2 words buffered
  - imem_req drops to 0 (WAIT)
  - first word is re-presented unchanged when dec_ready returns
- Redirect to 16'h0040 while a request is outstanding with imem_rdy delayed 3 cycles:
  - late response discarded
  - next imem_addr=0040
  - no stale inst_valid
- Fetched word 16'h0000 at address 0006:
  - word delivered with pc2_out=0008
  - halted=1, imem_req stays 0
  - a later redirect to 0010 resumes fetch
- redirect_pc=16'h0011: err=1 and halted=1 on the next cycle, FIFO empty, err held until rst=0.
- PC at 16'hFFFE accepted: next imem_addr=16'h0000, pc2_out=16'h0000.
